// File: rtl/ldpc_wb_addr_gen.sv
// ldpc_wb_addr_gen
// Write-back address generator for the LDPC message memory. Every read
// address issued to the processing pipeline goes into a small in-order queue.
// When the processing unit returns the matching result word, the head address
// and that word are emitted one cycle later as a registered memory write.
// The block also counts completed write-backs per frame and keeps sticky
// overflow and underflow flags.
//
// Ports:
//   clk, reset     clock; asynchronous active-low reset
//   clr            synchronous flush: queue, frame counter and error flags
//   rd_valid/addr  push an issued read address
//   res_valid/data pop the head address and pair it with the result word
//   wr_en/addr/data registered memory write
//   level/full/empty queue occupancy
//   wr_count       write-backs completed in the current frame
//   frame_done     one-cycle pulse on the last write of a frame
//   err_ovf/unf    sticky: push dropped / pop seen with an empty queue
module ldpc_wb_addr_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     rd_valid,
    input  logic [DATA_WIDTH-1:0]    rd_addr,
    input  logic                     res_valid,
    input  logic [WORD_WIDTH-1:0]    res_data,
    output logic                     wr_en,
    output logic [DATA_WIDTH-1:0]    wr_addr,
    output logic [WORD_WIDTH-1:0]    wr_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [DATA_WIDTH-1:0]    wr_count,
    output logic                     frame_done,
    output logic                     err_ovf,
    output logic                     err_unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0]         DEPTH_L  = LW'(DEPTH);
    // FRAME_LEN may equal 2^DATA_WIDTH, so compare against the last count
    // rather than against FRAME_LEN itself.
    localparam logic [DATA_WIDTH-1:0] LAST_CNT = DATA_WIDTH'(FRAME_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic                  pop_ok, push_ok;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // A push into a full queue still fits when the head leaves in the same
    // cycle. A pop never sees a push from the same cycle because there is no
    // bypass path.
    assign pop_ok  = res_valid && !empty;
    assign push_ok = rd_valid && (!full || pop_ok);

    // Queue storage has no reset. Its contents do not matter once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wptr] <= rd_addr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + PW'(1);
            if (pop_ok)
                rptr <= rptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (rd_valid && !push_ok)
                err_ovf <= 1'b1;
            if (res_valid && empty)
                err_unf <= 1'b1;
        end
    end

    // Write port. wr_addr and wr_data are only loaded on a pop, so they hold
    // their last values while wr_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_count   <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            wr_en      <= 1'b0;
            wr_count   <= '0;
            frame_done <= 1'b0;
        end else if (pop_ok) begin
            wr_en      <= 1'b1;
            wr_addr    <= mem[rptr];
            wr_data    <= res_data;
            wr_count   <= (wr_count == LAST_CNT) ? '0 : wr_count + DATA_WIDTH'(1);
            frame_done <= (wr_count == LAST_CNT);
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ldpc_wb_addr_gen.sv
// Bench for ldpc_wb_addr_gen. A queue-based reference model tracks the
// expected outputs, and a compare process checks them on every falling edge.
// Directed literal checks fix the key results of each scenario.
module tb_ldpc_wb_addr_gen;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int DEPTH = 8;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_addr = '0;
    logic          res_valid = 1'b0;
    logic [WW-1:0] res_data = '0;
    logic          wr_en;
    logic [DW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic [3:0]    level;
    logic          full, empty;
    logic [DW-1:0] wr_count;
    logic          frame_done, err_ovf, err_unf;

    int tests = 0;
    int fails = 0;

    ldpc_wb_addr_gen #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .rd_valid(rd_valid), .rd_addr(rd_addr),
        .res_valid(res_valid), .res_data(res_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .level(level), .full(full), .empty(empty),
        .wr_count(wr_count), .frame_done(frame_done),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [DW-1:0] m_q[$];
    logic          m_wr_en = 1'b0;
    logic [DW-1:0] m_wr_addr = '0;
    logic [WW-1:0] m_wr_data = '0;
    int            m_cnt = 0;
    logic          m_fd = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
            m_cnt = 0; m_fd = 0; m_ovf = 0; m_unf = 0;
        end else if (clr) begin
            m_q.delete();
            m_wr_en = 0; m_fd = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_wr_en = 0;
            m_fd = 0;
            if (res_valid) begin
                if (m_q.size() > 0) begin
                    m_wr_addr = m_q.pop_front();
                    m_wr_data = res_data;
                    m_wr_en = 1;
                    m_cnt++;
                    if (m_cnt == FL) begin
                        m_cnt = 0;
                        m_fd = 1;
                    end
                end else begin
                    m_unf = 1;
                end
            end
            if (rd_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(rd_addr);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("wr_en", wr_en, m_wr_en);
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_data", wr_data, m_wr_data);
        check("level", level, m_q.size());
        check("full", full, m_q.size() == DEPTH);
        check("empty", empty, m_q.size() == 0);
        check("wr_count", wr_count, m_cnt);
        check("frame_done", frame_done, m_fd);
        check("err_ovf", err_ovf, m_ovf);
        check("err_unf", err_unf, m_unf);
    end

    // Apply one cycle of inputs and return 1ns after the rising edge.
    task automatic cyc(input logic rv, input logic [7:0] ra, input logic pv,
                       input logic [7:0] pd, input logic c);
        rd_valid = rv; rd_addr = ra; res_valid = pv; res_data = pd; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 8'h00, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_wr_en", wr_en, 0);
        reset = 1'b1;
        idle();

        // In-order write-back
        cyc(1, 8'h10, 0, 8'h00, 0);
        cyc(1, 8'h11, 0, 8'h00, 0);
        cyc(1, 8'h12, 0, 8'h00, 0);
        check("t1_level3", level, 3);
        cyc(0, 8'h00, 1, 8'hA0, 0);
        check("t1_w0_en", wr_en, 1);
        check("t1_w0", {wr_addr, wr_data}, 16'h10A0);
        cyc(0, 8'h00, 1, 8'hA1, 0);
        check("t1_w1", {wr_addr, wr_data}, 16'h11A1);
        cyc(0, 8'h00, 1, 8'hA2, 0);
        check("t1_w2", {wr_addr, wr_data}, 16'h12A2);
        check("t1_level0", level, 0);
        check("t1_empty", empty, 1);
        check("t1_count", wr_count, 3);
        idle();
        check("t1_hold", {wr_en, wr_addr, wr_data}, 17'h012A2);
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Overflow, then a push plus pop while full
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h30 + i), 0, 8'h00, 0);
        check("t2_level", level, 8);
        check("t2_full", full, 1);
        check("t2_ovf", err_ovf, 1);
        cyc(1, 8'h55, 1, 8'hB0, 0);
        check("t2_wr", {wr_en, wr_addr, wr_data}, 17'h130B0);
        check("t2_level_kept", level, 8);
        check("t2_ovf_sticky", err_ovf, 1);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 8'(8'hB1 + i), 0);
        check("t2_last_addr", wr_addr, 8'h55);
        idle();
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Pop with an empty queue while pushing
        cyc(1, 8'h20, 1, 8'hC5, 0);
        check("t3_unf", err_unf, 1);
        check("t3_no_wr", wr_en, 0);
        check("t3_level", level, 1);
        cyc(0, 8'h00, 1, 8'hC0, 0);
        check("t3_wr", {wr_en, wr_addr, wr_data}, 17'h120C0);
        idle();
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Frame wrap at FRAME_LEN=4
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'(8'h40 + i), 0, 8'h00, 0);
            cyc(0, 8'h00, 1, 8'(8'h60 + i), 0);
            check("t4_count", wr_count, (i + 1) % 4);
            check("t4_fd", frame_done, i == 3);
            check("t4_wr_en", wr_en, 1);
        end
        idle();
        cyc(0, 8'h00, 0, 8'h00, 1);

        // clr takes priority over a same-cycle push and pop
        cyc(0, 8'h00, 1, 8'h00, 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h70 + i), 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 8'(8'hD0 + i), 0);
        check("t5_level5", level, 5);
        check("t5_flags", {err_ovf, err_unf}, 2'b11);
        cyc(1, 8'h77, 1, 8'hEE, 1);
        check("t5_level0", level, 0);
        check("t5_empty", empty, 1);
        check("t5_count", wr_count, 0);
        check("t5_flags0", {err_ovf, err_unf}, 2'b00);
        check("t5_wr_en", wr_en, 0);

        // Asynchronous reset with three addresses queued
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h80 + i), 0, 8'h00, 0);
        rd_valid = 0;
        check("t6_level3", level, 3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_level", level, 0);
        check("t6_async_empty", empty, 1);
        check("t6_async_wr", {wr_en, wr_addr, wr_data}, 17'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 8'h00, 1, 8'hF0, 0);
        check("t6_unf", err_unf, 1);
        check("t6_no_wr", wr_en, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
